power_sequencer: RTL and testbench
==================================

Name: power_sequencer

Overview:
- Cycle-level power-gating controller for the MIPS core domain. Sits beside mips/imem in top and replaces the ad-hoc NOP counter.
- Detects idle as a run of consecutive NOP fetches, then sequences isolate -> retention save -> switch-off handshake -> off -> switch-on handshake -> settle -> restore -> de-isolate.
- Stalls the PC while the domain is not ON.
- Sets a sticky error flag on a switch handshake timeout.

Parameters:
- IDLE_THRESH, 10: consecutive NOP cycles that trigger power-down (range 1..2^CNT_W-1).
- CNT_W, 4: idle counter width.
- ACK_TIMEOUT, 15: maximum cycles spent waiting on sw_ack in either handshake state.
- SETTLE_CYC, 2: cycles held in SETTLE after power-up ack, before restore.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-low reset. Asserted when 0.
- instr, input, 32: current fetched instruction from imem.
- wake_req, input, 1: level wake request from external event logic.
- sw_ack, input, 1: power switch chain status. 1 = domain fully off, 0 = fully on.
- sw_ctrl_net, output, 1: switch control. 1 = request power off.
- iso_enable, output, 1: clamp domain outputs.
- save, output, 1: one-cycle retention save pulse.
- restore, output, 1: one-cycle retention restore pulse.
- stall, output, 1: hold PC / block register and memory writes.
- pwr_err, output, 1: sticky handshake timeout flag.
- pwr_state, output, 4: encoded current state, for debug.

Behaviour:
- Reset (reset=0, asynchronous): state ON, idle counter 0, timer 0. All outputs 0.
- All outputs are registered Moore decodes of the state register and change on the same edge as the state transition. They must be glitch-free.
- States: ON, ISO, SAVE, PWR_DN, OFF, PWR_UP, SETTLE, RESTORE, DE_ISO.
- Idle counter (ON only):
  - instr == 32'h20000000 (NOP): counter increments.
  - Any other instr: counter clears to 0.
  - NOP with counter == IDLE_THRESH-1: next state ISO, counter clears.
  - Net effect: ISO is entered on the edge that samples the IDLE_THRESH-th consecutive NOP.
  - wake_req=1 in ON holds the counter at 0, so the block never powers down while a wake is pending.
- ISO: iso_enable=1, stall=1, one cycle. Next state SAVE.
- SAVE: save=1 for exactly one cycle. Next state PWR_DN.
- PWR_DN: sw_ctrl_net=1, timer counts.
  - sw_ack=1: next state OFF.
  - Timer reaches ACK_TIMEOUT: set pwr_err, next state PWR_UP (abort power-down).
- OFF: sw_ctrl_net=1. Stays until wake_req=1, then next state PWR_UP.
- PWR_UP: sw_ctrl_net=0, timer counts.
  - sw_ack=0: next state SETTLE.
  - Timeout: set pwr_err, stay in PWR_UP (never de-isolate an unpowered domain). Timer saturates.
- SETTLE: hold SETTLE_CYC cycles, then next state RESTORE.
- RESTORE: restore=1 for one cycle. Next state DE_ISO.
- DE_ISO: iso_enable=0, stall=1 for one cycle. Next state ON, with stall=0 on entry to ON.
- iso_enable is 1 in every state from ISO through RESTORE inclusive.
- stall is 1 in every state except ON.
- Wake abort: wake_req=1 during ISO or SAVE goes directly to DE_ISO. No restore pulse, and save is not issued if aborting from ISO.
- wake_req=1 during PWR_DN: the handshake completes to OFF, then OFF leaves on the next cycle.
- Timer clears on every state entry.
- pwr_err clears only on reset.
- Reset mid-sequence: immediate return to ON with all outputs 0. The switch powers back up under its own reset.

Optional Feature:
- Macro: POWER_SEQ_RETENTION_EN.
- Defined: the SAVE and RESTORE states exist and save/restore pulse as above.
- Undefined:
  - SAVE and RESTORE states are removed. ISO goes to PWR_DN and SETTLE goes to DE_ISO.
  - save and restore are tied to 0.
  - Power-down latency drops by one cycle each way.

Decomposition:
- power_pkg holds:
  - pwr_state_t enum with fixed 4-bit encodings: ON=0, ISO=1, SAVE=2, PWR_DN=3, OFF=4, PWR_UP=5, SETTLE=6, RESTORE=7, DE_ISO=8.
  - NOP_INSTR = 32'h20000000.
- One sub-module: nop_idle_counter. Inputs clk, reset, en, instr, clr. Output hit, asserted for the IDLE_THRESH-th consecutive NOP.

Test Plan:
- Power-down sequence: 9 NOPs then ADD -> counter clears and state stays ON. Then 10 NOPs -> ISO on the 10th edge, SAVE one cycle later, sw_ctrl_net=1 one cycle after that.
- Full sleep/wake: sw_ack rises 3 cycles into PWR_DN -> OFF. Then wake_req=1 -> PWR_UP. sw_ack falls after 2 cycles -> SETTLE for 2 cycles, restore pulse, DE_ISO, ON. Check iso_enable and stall cover the whole window and drop as specified.
- Abort: wake_req=1 during ISO -> DE_ISO next, save never pulses, sw_ctrl_net stays 0, back in ON 2 cycles after ISO entry.
- Timeout: sw_ack held 0 in PWR_DN for 15 cycles -> pwr_err=1, PWR_UP, normal recovery. pwr_err stays 1 until reset.
- Reset mid-OFF: reset=0 asynchronously -> all outputs 0 and pwr_state=0 without waiting for a clock edge.
- Build without POWER_SEQ_RETENTION_EN: repeat the full sleep/wake scenario -> save/restore stay 0 and each path is one cycle shorter.

Source files
------------

// File: rtl/power_pkg.sv
// Shared types and constants for the MIPS core-domain power sequencer.
// The state encodings are fixed because pwr_state is exported for debug.
package power_pkg;

  typedef enum logic [3:0] {
    ON      = 4'd0,
    ISO     = 4'd1,
    SAVE    = 4'd2,
    PWR_DN  = 4'd3,
    OFF     = 4'd4,
    PWR_UP  = 4'd5,
    SETTLE  = 4'd6,
    RESTORE = 4'd7,
    DE_ISO  = 4'd8
  } pwr_state_t;

  // addi $0,$0,0 as emitted by the toolchain for a NOP fetch
  localparam logic [31:0] NOP_INSTR = 32'h2000_0000;

  typedef struct packed {
    logic sw_ctrl_net;
    logic iso_enable;
    logic save;
    logic restore;
    logic stall;
  } pwr_ctrl_t;

  // Moore decode of the domain control outputs for a given state
  function automatic pwr_ctrl_t decode_ctrl(input pwr_state_t s);
    pwr_ctrl_t c;
    c = '0;
    c.stall       = (s != ON);
    c.iso_enable  = (s inside {ISO, SAVE, PWR_DN, OFF, PWR_UP, SETTLE, RESTORE});
    c.sw_ctrl_net = (s == PWR_DN) || (s == OFF);
    c.save        = (s == SAVE);
    c.restore     = (s == RESTORE);
    return c;
  endfunction

endpackage

// File: rtl/power_sequencer_if.sv
// Bundle of the sequencer's core-side and switch-side signals.
// master: the sequencer itself; slave: the core/switch environment.
interface power_sequencer_if;
  import power_pkg::*;

  logic [31:0] instr;
  logic        wake_req;
  logic        sw_ack;
  logic        sw_ctrl_net;
  logic        iso_enable;
  logic        save;
  logic        restore;
  logic        stall;
  logic        pwr_err;
  pwr_state_t  pwr_state;

  modport master (
    input  instr, wake_req, sw_ack,
    output sw_ctrl_net, iso_enable, save, restore, stall, pwr_err, pwr_state
  );

  modport slave (
    output instr, wake_req, sw_ack,
    input  sw_ctrl_net, iso_enable, save, restore, stall, pwr_err, pwr_state
  );

endinterface

// File: rtl/nop_idle_counter.sv
// Counts consecutive NOP fetches; hit fires on the IDLE_THRESH-th one,
// and the count restarts from zero on that same edge.
module nop_idle_counter
  import power_pkg::*;
#(
  parameter int IDLE_THRESH = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [31:0] instr,
  input  logic        clr,
  output logic        hit
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(IDLE_THRESH - 1);

  logic [CNT_W-1:0] count;
  logic             is_nop;

  assign is_nop = (instr == NOP_INSTR);
  assign hit    = en && !clr && is_nop && (count == LAST);

  // Run-length of NOPs; any other fetch, a clear, or a hit restarts it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      if (!is_nop || hit) count <= '0;
      else                count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/power_sequencer.sv
// Power-gating controller for the MIPS core domain.
// Build option: define POWER_SEQ_RETENTION_EN to include the SAVE/RESTORE
// retention states; without it the sequence skips them and save/restore stay 0.
module power_sequencer
  import power_pkg::*;
#(
  parameter int IDLE_THRESH = 10,
  parameter int CNT_W       = 4,
  parameter int ACK_TIMEOUT = 15,
  parameter int SETTLE_CYC  = 2
) (
  input  logic               clk,
  input  logic               reset,
  power_sequencer_if.master  pif
);

  localparam int TMR_MAX = (ACK_TIMEOUT > SETTLE_CYC) ? ACK_TIMEOUT : SETTLE_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] TMR_SAT     = TMR_W'(TMR_MAX);
  localparam logic [TMR_W-1:0] ACK_LAST    = TMR_W'(ACK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYC - 1);

`ifdef POWER_SEQ_RETENTION_EN
  localparam pwr_state_t AFTER_ISO    = SAVE;
  localparam pwr_state_t AFTER_SETTLE = RESTORE;
`else
  localparam pwr_state_t AFTER_ISO    = PWR_DN;
  localparam pwr_state_t AFTER_SETTLE = DE_ISO;
`endif

  pwr_state_t       state, state_next;
  logic [TMR_W-1:0] tmr, tmr_next;
  logic             err_q, err_next;
  pwr_ctrl_t        ctrl_q, ctrl_next;
  logic             idle_en, idle_clr, idle_hit;
  logic             ack_timeout;

  assign idle_en     = (state == ON);
  assign idle_clr    = (state != ON) || pif.wake_req;
  assign ack_timeout = (tmr >= ACK_LAST);

  nop_idle_counter #(
    .IDLE_THRESH (IDLE_THRESH),
    .CNT_W       (CNT_W)
  ) u_idle (
    .clk   (clk),
    .reset (reset),
    .en    (idle_en),
    .instr (pif.instr),
    .clr   (idle_clr),
    .hit   (idle_hit)
  );

  // Next state, handshake timer and the outputs that belong to the next state
  always_comb begin
    state_next = state;
    err_next   = err_q;
    tmr_next   = tmr;
    ctrl_next  = '0;

    case (state)
      ON: begin
        if (idle_hit) state_next = ISO;
      end
      ISO: begin
        if (pif.wake_req) state_next = DE_ISO;
        else              state_next = AFTER_ISO;
      end
`ifdef POWER_SEQ_RETENTION_EN
      SAVE: begin
        if (pif.wake_req) state_next = DE_ISO;
        else              state_next = PWR_DN;
      end
      RESTORE: begin
        state_next = DE_ISO;
      end
`endif
      PWR_DN: begin
        if (pif.sw_ack) begin
          state_next = OFF;
        end else if (ack_timeout) begin
          err_next   = 1'b1;
          state_next = PWR_UP;
        end
      end
      OFF: begin
        if (pif.wake_req) state_next = PWR_UP;
      end
      PWR_UP: begin
        if (!pif.sw_ack)      state_next = SETTLE;
        else if (ack_timeout) err_next   = 1'b1;
      end
      SETTLE: begin
        if (tmr == SETTLE_LAST) state_next = AFTER_SETTLE;
      end
      DE_ISO: begin
        state_next = ON;
      end
      default: begin
        state_next = ON;
      end
    endcase

    if (state_next != state) tmr_next = '0;
    else if (tmr != TMR_SAT) tmr_next = tmr + 1'b1;

    ctrl_next = decode_ctrl(state_next);
`ifdef POWER_SEQ_RETENTION_EN
`else
    ctrl_next.save    = 1'b0;
    ctrl_next.restore = 1'b0;
`endif
  end

  // State, timer, sticky error and registered glitch-free outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ON;
      tmr    <= '0;
      err_q  <= 1'b0;
      ctrl_q <= '0;
    end else begin
      state  <= state_next;
      tmr    <= tmr_next;
      err_q  <= err_next;
      ctrl_q <= ctrl_next;
    end
  end

  assign pif.sw_ctrl_net = ctrl_q.sw_ctrl_net;
  assign pif.iso_enable  = ctrl_q.iso_enable;
  assign pif.save        = ctrl_q.save;
  assign pif.restore     = ctrl_q.restore;
  assign pif.stall       = ctrl_q.stall;
  assign pif.pwr_err     = err_q;
  assign pif.pwr_state   = state;

endmodule

// File: tb/tb_power_sequencer.sv
// Self-checking bench for power_sequencer: a reference model pushes the
// expected output word per driven cycle, compared after the following edge.
module tb_power_sequencer;
  import power_pkg::*;

  localparam int IDLE_THRESH = 10;
  localparam int ACK_TIMEOUT = 15;
  localparam int SETTLE_CYC  = 2;
  localparam logic [31:0] ADD_INSTR = 32'h0022_1820;

`ifdef POWER_SEQ_RETENTION_EN
  localparam bit RET = 1'b1;
`else
  localparam bit RET = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;

  power_sequencer_if pif();

  power_sequencer #(
    .IDLE_THRESH (IDLE_THRESH),
    .CNT_W       (4),
    .ACK_TIMEOUT (ACK_TIMEOUT),
    .SETTLE_CYC  (SETTLE_CYC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .pif   (pif)
  );

  // Free-running 100 MHz clock
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [9:0] sb_q[$];

  pwr_state_t m_state;
  int         m_cnt;
  int         m_tmr;
  bit         m_err;

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] observed();
    return {pif.pwr_state, pif.pwr_err, pif.stall, pif.restore, pif.save,
            pif.iso_enable, pif.sw_ctrl_net};
  endfunction

  // {stall, restore, save, iso_enable, sw_ctrl_net} expected in each state
  function automatic logic [9:0] expect_word(input pwr_state_t s, input bit err);
    logic [4:0] f;
    case (s)
      ON:      f = 5'b00000;
      ISO:     f = 5'b10010;
      SAVE:    f = 5'b10110;
      PWR_DN:  f = 5'b10011;
      OFF:     f = 5'b10011;
      PWR_UP:  f = 5'b10010;
      SETTLE:  f = 5'b10010;
      RESTORE: f = 5'b11010;
      DE_ISO:  f = 5'b10000;
      default: f = 5'b11111;
    endcase
    return {s, err, f};
  endfunction

  task automatic model_reset();
    m_state = ON;
    m_cnt   = 0;
    m_tmr   = 0;
    m_err   = 1'b0;
    sb_q.delete();
  endtask

  task automatic model_step(input logic [31:0] ins, input logic wk, input logic ack);
    pwr_state_t ns;
    ns = m_state;
    case (m_state)
      ON: begin
        if (wk) m_cnt = 0;
        else if (ins == NOP_INSTR) begin
          m_cnt++;
          if (m_cnt == IDLE_THRESH) begin
            ns    = ISO;
            m_cnt = 0;
          end
        end else m_cnt = 0;
      end
      ISO:    ns = wk ? DE_ISO : (RET ? SAVE : PWR_DN);
      SAVE:   ns = wk ? DE_ISO : PWR_DN;
      PWR_DN: begin
        m_tmr++;
        if (ack) ns = OFF;
        else if (m_tmr == ACK_TIMEOUT) begin
          m_err = 1'b1;
          ns    = PWR_UP;
        end
      end
      OFF:    if (wk) ns = PWR_UP;
      PWR_UP: begin
        m_tmr++;
        if (!ack) ns = SETTLE;
        else if (m_tmr >= ACK_TIMEOUT) m_err = 1'b1;
      end
      SETTLE: begin
        m_tmr++;
        if (m_tmr == SETTLE_CYC) ns = RET ? RESTORE : DE_ISO;
      end
      RESTORE: ns = DE_ISO;
      DE_ISO:  ns = ON;
      default: ns = ON;
    endcase
    if (ns != m_state) m_tmr = 0;
    m_state = ns;
    sb_q.push_back(expect_word(m_state, m_err));
  endtask

  task automatic apply_stimulus(input logic [31:0] ins, input logic wk, input logic ack);
    logic [9:0] exp;
    @(negedge clk);
    pif.instr    = ins;
    pif.wake_req = wk;
    pif.sw_ack   = ack;
    model_step(ins, wk, ack);
    @(posedge clk);
    #1;
    cyc++;
    if (sb_q.size() == 0) begin
      check_output("sb_underflow", 32'd1, 32'd0);
    end else begin
      exp = sb_q.pop_front();
      check_output($sformatf("cycle%0d", cyc), observed(), exp);
    end
  endtask

  task automatic run_nops(input int n, input logic wk);
    for (int i = 0; i < n; i++) apply_stimulus(NOP_INSTR, wk, 1'b0);
  endtask

  // From ON: reach ISO, then walk to PWR_DN (one extra step with retention)
  task automatic go_to_pwr_dn();
    run_nops(IDLE_THRESH, 1'b0);
    check_output("iso_entry", pif.pwr_state, ISO);
    for (int i = 0; i < (RET ? 2 : 1); i++) apply_stimulus(ADD_INSTR, 1'b0, 1'b0);
    check_output("pwr_dn_entry", pif.pwr_state, PWR_DN);
  endtask

  task automatic recover_to_on();
    for (int i = 0; i < 5; i++) apply_stimulus(ADD_INSTR, 1'b0, 1'b0);
  endtask

  // Directed scenarios, a random soak, then asynchronous reset mid-OFF
  initial begin
    reset        = 1'b0;
    pif.instr    = ADD_INSTR;
    pif.wake_req = 1'b0;
    pif.sw_ack   = 1'b0;
    model_reset();
    #12;
    check_output("reset_outputs", observed(), 10'd0);
    @(negedge clk);
    reset = 1'b1;

    run_nops(IDLE_THRESH - 1, 1'b0);
    apply_stimulus(ADD_INSTR, 1'b0, 1'b0);
    check_output("nop9_add_stays_on", pif.pwr_state, ON);

    run_nops(IDLE_THRESH, 1'b0);
    check_output("iso_10th_nop", pif.pwr_state, ISO);
    check_output("iso_clamp", {pif.iso_enable, pif.stall, pif.sw_ctrl_net}, 3'b110);
    if (RET) begin
      apply_stimulus(ADD_INSTR, 1'b0, 1'b0);
      check_output("save_pulse", pif.save, 1'b1);
    end
    apply_stimulus(ADD_INSTR, 1'b0, 1'b0);
    check_output("sw_ctrl_up", pif.sw_ctrl_net, 1'b1);
    apply_stimulus(ADD_INSTR, 1'b0, 1'b0);
    apply_stimulus(ADD_INSTR, 1'b0, 1'b1);
    check_output("off_entry", pif.pwr_state, OFF);
    apply_stimulus(ADD_INSTR, 1'b0, 1'b1);
    apply_stimulus(ADD_INSTR, 1'b1, 1'b1);
    check_output("pwr_up_entry", {pif.pwr_state, pif.sw_ctrl_net, pif.iso_enable}, {PWR_UP, 2'b01});
    apply_stimulus(ADD_INSTR, 1'b1, 1'b1);
    apply_stimulus(ADD_INSTR, 1'b1, 1'b0);
    check_output("settle_entry", pif.pwr_state, SETTLE);
    apply_stimulus(ADD_INSTR, 1'b1, 1'b0);
    check_output("settle_hold", pif.pwr_state, SETTLE);
    apply_stimulus(ADD_INSTR, 1'b1, 1'b0);
    if (RET) begin
      check_output("restore_pulse", pif.restore, 1'b1);
      apply_stimulus(ADD_INSTR, 1'b1, 1'b0);
    end
    check_output("de_iso", {pif.pwr_state, pif.iso_enable, pif.stall}, {DE_ISO, 2'b01});
    apply_stimulus(ADD_INSTR, 1'b0, 1'b0);
    check_output("back_on", {pif.pwr_state, pif.stall}, {ON, 1'b0});

    run_nops(IDLE_THRESH, 1'b0);
    apply_stimulus(NOP_INSTR, 1'b1, 1'b0);
    check_output("abort_de_iso", pif.pwr_state, DE_ISO);
    apply_stimulus(NOP_INSTR, 1'b1, 1'b0);
    check_output("abort_on", pif.pwr_state, ON);
    run_nops(IDLE_THRESH + 2, 1'b1);
    check_output("wake_blocks_idle", pif.pwr_state, ON);
    apply_stimulus(ADD_INSTR, 1'b0, 1'b0);

    go_to_pwr_dn();
    apply_stimulus(ADD_INSTR, 1'b1, 1'b0);
    check_output("wake_in_pwr_dn", pif.pwr_state, PWR_DN);
    apply_stimulus(ADD_INSTR, 1'b1, 1'b1);
    apply_stimulus(ADD_INSTR, 1'b1, 1'b1);
    check_output("off_leaves_next", pif.pwr_state, PWR_UP);
    recover_to_on();

    go_to_pwr_dn();
    for (int i = 0; i < ACK_TIMEOUT - 1; i++) apply_stimulus(ADD_INSTR, 1'b0, 1'b0);
    check_output("pre_timeout", {pif.pwr_state, pif.pwr_err}, {PWR_DN, 1'b0});
    apply_stimulus(ADD_INSTR, 1'b0, 1'b0);
    check_output("timeout", {pif.pwr_state, pif.pwr_err}, {PWR_UP, 1'b1});
    recover_to_on();
    check_output("err_sticky", {pif.pwr_state, pif.pwr_err}, {ON, 1'b1});

    go_to_pwr_dn();
    apply_stimulus(ADD_INSTR, 1'b0, 1'b1);
    for (int i = 0; i < ACK_TIMEOUT + 5; i++) apply_stimulus(ADD_INSTR, 1'b1, 1'b1);
    check_output("pwr_up_hold", pif.pwr_state, PWR_UP);
    recover_to_on();

    for (int i = 0; i < 400; i++) begin
      apply_stimulus(($urandom_range(0, 9) < 8) ? NOP_INSTR : ADD_INSTR,
                     ($urandom_range(0, 15) == 0),
                     ($urandom_range(0, 2) == 0) ? ~pif.sw_ack : pif.sw_ack);
    end
    recover_to_on();

    go_to_pwr_dn();
    apply_stimulus(ADD_INSTR, 1'b0, 1'b1);
    check_output("off_before_reset", pif.pwr_state, OFF);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_output("async_reset", observed(), 10'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    run_nops(IDLE_THRESH, 1'b0);
    check_output("post_reset_iso", {pif.pwr_state, pif.pwr_err}, {ISO, 1'b0});
    recover_to_on();

    check_output("sb_empty", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
